// File: rtl/coherence_bus_arbiter_pkg.sv
// Shared coherence bus types: requester ids/vectors and the bus arbiter state encoding.
// Also holds the small wrap-increment helper used when priority rotates.
package coherence_bus_arbiter_pkg;

    localparam int CPUS    = 2;
    localparam int CPUID_W = $clog2(CPUS);

    typedef logic [CPUID_W-1:0] cpuid_t;
    typedef logic [CPUS-1:0]    cpus_bitvec_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_HOLD,
        ARB_RELEASE
    } arb_state_t;

    // Next index after id in a ring of n entries; n need not be a power of two.
    function automatic int wrap_inc(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping N-1 -> 0.
// Safe for non-power-of-two N as long as ptr < N.
module rr_priority_select #(
    parameter  int N   = 2,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   sel,
    output logic [IDW-1:0] idx,
    output logic           hit
);
    import coherence_bus_arbiter_pkg::*;

    int cand;

    always_comb begin
        sel  = '0;
        idx  = '0;
        hit  = 1'b0;
        cand = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) cand = cand - N;
            if (!hit && req[cand]) begin
                hit       = 1'b1;
                sel[cand] = 1'b1;
                idx       = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Round-robin owner of the single coherence bus controller: grants one L1, holds the grant
// through the controller's transaction, then drops it for one cycle and rotates priority.
module coherence_bus_arbiter #(
    parameter  int CPUS    = coherence_bus_arbiter_pkg::CPUS,
    parameter  int TIMEOUT = 1024,
    localparam int IDW     = $clog2(CPUS),
    localparam int WDW     = $clog2(TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            nRST,
    input  logic [CPUS-1:0] req,
    input  logic            txn_start,
    input  logic            txn_done,
    output logic [CPUS-1:0] grant,
    output logic            grant_valid,
    output logic [IDW-1:0]  grant_id,
    output logic            busy,
    output logic            timeout_err
);
    import coherence_bus_arbiter_pkg::*;

    arb_state_t      state_q, state_d;
    logic [CPUS-1:0] grant_q, grant_d;
    logic            grant_valid_q, grant_valid_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            busy_q, busy_d;
    logic            timeout_err_q, timeout_err_d;
    logic [WDW-1:0]  wdog_q, wdog_d;

    logic [CPUS-1:0] pick_sel;
    logic [IDW-1:0]  pick_idx;
    logic            pick_hit;

    rr_priority_select #(.N(CPUS)) u_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .sel (pick_sel),
        .idx (pick_idx),
        .hit (pick_hit)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        timeout_err_d = timeout_err_q;
        wdog_d        = wdog_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_hit) begin
                    grant_d    = pick_sel;
                    grant_id_d = pick_idx;
                    state_d    = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                // A start in the same cycle as a withdrawal still wins: the controller has committed.
                if (txn_start) begin
                    state_d = ARB_HOLD;
                    wdog_d  = '0;
                end else if (!req[grant_id_q]) begin
                    grant_d = '0;
                    state_d = ARB_IDLE;
                end
            end
            ARB_HOLD: begin
                if (wdog_q != WDW'(TIMEOUT)) wdog_d = wdog_q + 1'b1;
                if (txn_done) begin
                    grant_d  = '0;
                    state_d  = ARB_RELEASE;
                    rr_ptr_d = IDW'(wrap_inc(int'(grant_id_q), CPUS));
                end else if (wdog_q >= WDW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                end
            end
            ARB_RELEASE: state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
        grant_valid_d = |grant_d;
        busy_d        = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            rr_ptr_q      <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            wdog_q        <= wdog_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed bench for the coherence bus arbiter: CPUS=2, CPUS=3 and a short-watchdog instance.
module tb_coherence_bus_arbiter;

    logic clk = 1'b0;
    logic nRST = 1'b0;
    int checks = 0;
    int errors = 0;

    logic [1:0] req2 = '0;  logic ts2 = 0, td2 = 0;
    logic [1:0] g2;  logic gv2, gid2, busy2, err2;
    logic [2:0] req3 = '0;  logic ts3 = 0, td3 = 0;
    logic [2:0] g3;  logic gv3, busy3, err3;  logic [1:0] gid3;
    logic [1:0] reqw = '0;  logic tsw = 0, tdw = 0;
    logic [1:0] gw;  logic gvw, gidw, busyw, errw;

    always #5 clk = ~clk;

    coherence_bus_arbiter #(.CPUS(2), .TIMEOUT(1024)) d2 (
        .clk(clk), .nRST(nRST), .req(req2), .txn_start(ts2), .txn_done(td2),
        .grant(g2), .grant_valid(gv2), .grant_id(gid2), .busy(busy2), .timeout_err(err2));
    coherence_bus_arbiter #(.CPUS(3), .TIMEOUT(1024)) d3 (
        .clk(clk), .nRST(nRST), .req(req3), .txn_start(ts3), .txn_done(td3),
        .grant(g3), .grant_valid(gv3), .grant_id(gid3), .busy(busy3), .timeout_err(err3));
    coherence_bus_arbiter #(.CPUS(2), .TIMEOUT(8)) dw (
        .clk(clk), .nRST(nRST), .req(reqw), .txn_start(tsw), .txn_done(tdw),
        .grant(gw), .grant_valid(gvw), .grant_id(gidw), .busy(busyw), .timeout_err(errw));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        req2 = '0; ts2 = 0; td2 = 0;
        req3 = '0; ts3 = 0; td3 = 0;
        reqw = '0; tsw = 0; tdw = 0;
        step();
        step();
        #2 nRST = 1'b1;
        step();
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({g2, gv2, gid2, busy2, err2} !== 6'b0) begin
            errors++; $display("FAIL reset_d2 got=%b exp=000000", {g2, gv2, gid2, busy2, err2});
        end
        checks++;
        if ({g3, gv3, gid3, busy3, err3} !== 8'b0) begin
            errors++; $display("FAIL reset_d3 got=%b exp=00000000", {g3, gv3, gid3, busy3, err3});
        end
        checks++;
        if ({gw, gvw, gidw, busyw, errw} !== 6'b0) begin
            errors++; $display("FAIL reset_dw got=%b exp=000000", {gw, gvw, gidw, busyw, errw});
        end
        #2 nRST = 1'b1;
        step();
    endtask

    task automatic test_single();
        do_reset();
        req2 = 2'b10;
        step();
        checks++;
        if ({g2, gv2, gid2, busy2} !== 5'b10111) begin
            errors++; $display("FAIL single_grant got=%b exp=10111", {g2, gv2, gid2, busy2});
        end
        step();
        ts2 = 1;
        step();
        ts2 = 0; req2 = 2'b00;
        step();
        step();
        checks++;
        if ({g2, gid2} !== 3'b101) begin
            errors++; $display("FAIL single_hold got=%b exp=101", {g2, gid2});
        end
        td2 = 1;
        step();
        td2 = 0;
        checks++;
        if ({g2, gv2, gid2, busy2} !== 5'b00011) begin
            errors++; $display("FAIL single_release got=%b exp=00011", {g2, gv2, gid2, busy2});
        end
        step();
        checks++;
        if ({g2, busy2} !== 3'b000) begin
            errors++; $display("FAIL single_idle got=%b exp=000", {g2, busy2});
        end
        req2 = 2'b11;
        step();
        checks++;
        if ({g2, gid2} !== 3'b010) begin
            errors++; $display("FAIL single_ptr_wrap got=%b exp=010", {g2, gid2});
        end
        req2 = 2'b00;
        step();
    endtask

    task automatic test_fairness();
        logic [1:0] exp;
        int w;
        do_reset();
        req2 = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            w = 0;
            while (!gv2 && w < 10) begin
                step();
                w++;
            end
            checks++;
            if (!gv2) begin
                errors++; $display("FAIL fair_wait_%0d got=no_grant exp=grant", k);
            end else if (k > 0 && w != 2) begin
                errors++; $display("FAIL fair_spacing_%0d got=%0d exp=2", k, w);
            end
            checks++;
            if (g2 !== exp) begin
                errors++; $display("FAIL fair_grant_%0d got=%b exp=%b", k, g2, exp);
            end
            ts2 = 1; step(); ts2 = 0;
            step();
            td2 = 1; step(); td2 = 0;
        end
        req2 = 2'b00;
        step();
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        req3 = 3'b010;
        step();
        checks++;
        if ({g3, gid3} !== 5'b01001) begin
            errors++; $display("FAIL wrap_first got=%b exp=01001", {g3, gid3});
        end
        ts3 = 1; step(); ts3 = 0; req3 = 3'b000;
        td3 = 1; step(); td3 = 0;
        req3 = 3'b011;
        step();
        step();
        checks++;
        if ({g3, gid3} !== 5'b00100) begin
            errors++; $display("FAIL wrap_past_top got=%b exp=00100", {g3, gid3});
        end
        req3 = 3'b000;
        step();
        req3 = 3'b101;
        step();
        checks++;
        if ({g3, gid3} !== 5'b10010) begin
            errors++; $display("FAIL wrap_at_ptr got=%b exp=10010", {g3, gid3});
        end
        ts3 = 1; step(); ts3 = 0; req3 = 3'b000;
        td3 = 1; step(); td3 = 0;
        req3 = 3'b101;
        step();
        step();
        checks++;
        if ({g3, gid3} !== 5'b00100) begin
            errors++; $display("FAIL wrap_from_last got=%b exp=00100", {g3, gid3});
        end
        req3 = 3'b000;
        step();
    endtask

    task automatic test_abort();
        do_reset();
        req2 = 2'b01;
        step();
        req2 = 2'b00;
        step();
        checks++;
        if ({g2, gv2, busy2} !== 4'b0000) begin
            errors++; $display("FAIL abort_clear got=%b exp=0000", {g2, gv2, busy2});
        end
        req2 = 2'b11;
        step();
        checks++;
        if ({g2, gid2} !== 3'b010) begin
            errors++; $display("FAIL abort_regrant got=%b exp=010", {g2, gid2});
        end
        ts2 = 1; step(); ts2 = 0; req2 = 2'b10;
        td2 = 1; step(); td2 = 0;
        step();
        step();
        req2 = 2'b00;
        step();
        req2 = 2'b11;
        step();
        checks++;
        if ({g2, gid2} !== 3'b101) begin
            errors++; $display("FAIL abort_keeps_ptr got=%b exp=101", {g2, gid2});
        end
        req2 = 2'b00; ts2 = 1;
        step();
        ts2 = 0;
        step();
        checks++;
        if ({g2, busy2} !== 3'b101) begin
            errors++; $display("FAIL start_beats_withdraw got=%b exp=101", {g2, busy2});
        end
        td2 = 1; step(); td2 = 0;
        step();
        td2 = 1; ts2 = 1; step(); td2 = 0; ts2 = 0;
        checks++;
        if ({g2, busy2} !== 3'b000) begin
            errors++; $display("FAIL stray_pulses got=%b exp=000", {g2, busy2});
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        reqw = 2'b01;
        step();
        tsw = 1; step(); tsw = 0; reqw = 2'b00;
        repeat (7) step();
        checks++;
        if ({gw, errw} !== 3'b010) begin
            errors++; $display("FAIL wdog_early got=%b exp=010", {gw, errw});
        end
        step();
        checks++;
        if ({gw, busyw, errw} !== 4'b0111) begin
            errors++; $display("FAIL wdog_set got=%b exp=0111", {gw, busyw, errw});
        end
        tdw = 1; step(); tdw = 0;
        checks++;
        if ({gw, errw} !== 3'b001) begin
            errors++; $display("FAIL wdog_release got=%b exp=001", {gw, errw});
        end
        step();
        checks++;
        if ({busyw, errw} !== 2'b01) begin
            errors++; $display("FAIL wdog_sticky got=%b exp=01", {busyw, errw});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        reqw = 2'b10;
        step();
        tsw = 1; step(); tsw = 0; reqw = 2'b00;
        repeat (8) step();
        checks++;
        if ({gw, errw} !== 3'b101) begin
            errors++; $display("FAIL areset_pre got=%b exp=101", {gw, errw});
        end
        #3 nRST = 1'b0;
        #1;
        checks++;
        if ({gw, gvw, busyw, errw} !== 5'b00000) begin
            errors++; $display("FAIL areset_drop got=%b exp=00000", {gw, gvw, busyw, errw});
        end
        step();
        #2 nRST = 1'b1;
        reqw = 2'b11;
        step();
        checks++;
        if ({gw, gidw} !== 3'b010) begin
            errors++; $display("FAIL areset_regrant got=%b exp=010", {gw, gidw});
        end
        reqw = 2'b00;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_abort();
        test_watchdog();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/coherence_bus_arbiter.md
# coherence_bus_arbiter

- Round-robin arbiter that shares the single coherence bus controller between CPUS L1 requesters.
- Selects one requester, presents a one-hot grant with its cpuid to the bus controller, and holds the grant until that transaction finishes.
- Then releases the bus and rotates priority.
- Sits between the per-core L1 request lines and the bus controller's IDLE-state request decode; includes a hold-time watchdog.

## Interface
Parameters:
- CPUS, 2 — number of L1 requesters (≥2, need not be a power of two)
- TIMEOUT, 1024 — max cycles a grant may stay in HOLD before `timeout_err` sets

Ports:
- clk  in  1  — single clock, rising edge
- nRST  in  1  — asynchronous, active-low reset
- req  in  CPUS  — per-CPU bus request (dREN | dWEN | ccwrite of that L1); held until granted
- txn_start  in  1  — bus controller accepted the granted request (leaves IDLE)
- txn_done  in  1  — bus controller returned to IDLE; single-cycle pulse
- grant  out  CPUS  — one-hot grant, all-zero when none
- grant_valid  out  1  — OR of grant
- grant_id  out  $clog2(CPUS)  — index of the granted CPU (cpuid_t)
- busy  out  1  — arbiter not in ARB_IDLE
- timeout_err  out  1  — sticky watchdog flag

## Operation
- State machine states: ARB_IDLE, ARB_GRANT, ARB_HOLD, ARB_RELEASE.
- ARB_IDLE:
  - If req≠0, pick the first set bit at or after `rr_ptr`, searching upward and wrapping CPUS-1→0.
  - Register the choice in `grant` / `grant_id` and go to ARB_GRANT.
  - If req=0, stay in ARB_IDLE with grant=0.
- ARB_GRANT (grant asserted, waiting for the controller):
  - If txn_start=1, go to ARB_HOLD.
  - Else, if req[grant_id]=0 (requester withdrew), clear grant, go to ARB_IDLE, and leave `rr_ptr` unchanged (abort).
  - txn_start has priority over withdrawal in the same cycle.
- ARB_HOLD:
  - Grant is held regardless of req.
  - The watchdog counter increments each cycle.
  - If txn_done=1, go to ARB_RELEASE and set `rr_ptr` = grant_id+1, wrapping to 0 at CPUS.
  - If the counter reaches TIMEOUT-1 without txn_done, set `timeout_err`. It stays set until reset. The state does not change.
- ARB_RELEASE:
  - Grant is 0 for exactly one cycle, so the controller sees a clean deassert.
  - Unconditionally return to ARB_IDLE.
- Stray pulses: txn_done outside ARB_HOLD and txn_start outside ARB_GRANT are ignored.
- Watchdog counter: width $clog2(TIMEOUT+1); cleared on entry to ARB_HOLD; saturates (no wrap).
- Reset values: state=ARB_IDLE, rr_ptr=0, grant=0, grant_valid=0, grant_id=0, busy=0, timeout_err=0, counter=0.
- Reset mid-operation drops the grant immediately (asynchronously); no transaction state is retained.

## Timing
- All outputs are registered; none is combinational from inputs.
- Request-to-grant latency: req rising in cycle N with the arbiter idle → grant visible in cycle N+1.
- Minimum back-to-back spacing:
  - txn_done in cycle M → ARB_RELEASE in M+1 (grant=0).
  - ARB_IDLE in M+2 samples req.
  - Next grant in M+3.
- Same-cycle txn_start and txn_done in ARB_GRANT: txn_start is taken, and txn_done is ignored. The controller never does this, because its transactions take ≥2 cycles.
- grant_id holds its last value when grant=0. Consumers must qualify it with grant_valid.

## Structure
- Shared bus package: `cpuid_t`, `cpus_bitvec_t`, CPUS, and a new enum `arb_state_t` {ARB_IDLE, ARB_GRANT, ARB_HOLD, ARB_RELEASE}.
- Sub-module `rr_priority_select`: purely combinational. Inputs req and rr_ptr; outputs a one-hot select and its index. Handles the wrap for non-power-of-two CPUS. Reusable for the L2 port arbiter.
- FSM, pointer and watchdog live in the top module.

## Test plan
- **Single requester, CPUS=2:**
  - Stimulus: reset, then req=2'b10 at cycle 5, txn_start at 7, txn_done at 10.
  - Required: grant=2'b10 and grant_id=1 in cycles 6–10; grant=0 in 11; rr_ptr=0 afterwards.
- **Fairness:**
  - Stimulus: req=2'b11 held continuously; each transaction takes 3 cycles.
  - Required: grants alternate 01,10,01,10; no CPU is granted twice in a row.
- **Wrap with CPUS=3:**
  - Stimulus: rr_ptr=2 after a CPU1 grant; req=3'b011.
  - Required: grant=3'b001, i.e. the search wraps past index 2 to 0.
- **Abort:**
  - Stimulus: req=2'b01 granted; req drops before txn_start.
  - Required: grant clears next cycle, state returns to ARB_IDLE, rr_ptr is unchanged, and the next req=2'b11 grants CPU0.
- **Watchdog (TIMEOUT=8):**
  - Stimulus: grant → txn_start, and txn_done is never sent.
  - Required: timeout_err=1 after 8 HOLD cycles; the grant is still held. A later txn_done releases normally, and timeout_err stays 1 until nRST.
- **Async reset mid-HOLD:**
  - Stimulus: assert nRST=0 between clock edges while grant=2'b10.
  - Required: grant, busy and timeout_err go to 0 immediately; after release, req=2'b11 grants CPU0 first.
